// File: rtl/pe_mac_param.sv
// Parametrised systolic multiply-accumulate PE: forwards operands one cycle and emits
// one dot product of DEPTH accepted pairs, with optional signed math and saturation.
module pe_mac_param #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 24,
    parameter int DEPTH    = 4,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              block,
    input  logic              in_valid,
    input  logic              clear,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              out_valid,
    output logic [ACC_W-1:0]  val,
    output logic              val_valid,
    output logic              ovf
);

    localparam int               CNT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               PROD_W   = 2 * DATA_W;
    localparam logic             SGN      = (SIGNED != 0);
    localparam logic             SAT      = (SATURATE != 0);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    logic [ACC_W-1:0]  acc_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              ovf_acc_r;

    logic [PROD_W-1:0] a_ext_s;
    logic [PROD_W-1:0] b_ext_s;
    logic [PROD_W-1:0] prod_s;
    logic [ACC_W:0]    prod_ext_s;
    logic [ACC_W:0]    acc_ext_s;
    logic [ACC_W:0]    sum_s;
    logic              ovf_now_s;
    logic [ACC_W-1:0]  res_s;
    logic              last_s;

    // Product and one-bit-wider sum; the extra bit exposes overflow in both number systems.
    always_comb begin
        a_ext_s    = {{DATA_W{a[DATA_W-1] & SGN}}, a};
        b_ext_s    = {{DATA_W{b[DATA_W-1] & SGN}}, b};
        // Low PROD_W bits of the extended product equal the true signed/unsigned product.
        prod_s     = a_ext_s * b_ext_s;
        prod_ext_s = {{(ACC_W + 1 - PROD_W){prod_s[PROD_W-1] & SGN}}, prod_s};
        acc_ext_s  = {acc_r[ACC_W-1] & SGN, acc_r};
        sum_s      = acc_ext_s + prod_ext_s;
        if (SGN) begin
            ovf_now_s = sum_s[ACC_W] ^ sum_s[ACC_W-1];
        end else begin
            ovf_now_s = sum_s[ACC_W];
        end
        if (ovf_now_s && SAT) begin
            if (!SGN) begin
                res_s = {ACC_W{1'b1}};
            end else if (sum_s[ACC_W]) begin
                res_s = {1'b1, {(ACC_W - 1){1'b0}}};
            end else begin
                res_s = {1'b0, {(ACC_W - 1){1'b1}}};
            end
        end else begin
            res_s = sum_s[ACC_W-1:0];
        end
        last_s = (cnt_r == LAST_CNT);
    end

    // Pass-through registers, accumulator, product counter and result outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_out     <= {DATA_W{1'b0}};
            b_out     <= {DATA_W{1'b0}};
            out_valid <= 1'b0;
            val       <= {ACC_W{1'b0}};
            val_valid <= 1'b0;
            ovf       <= 1'b0;
            acc_r     <= {ACC_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            ovf_acc_r <= 1'b0;
        end else if (!block) begin
            a_out     <= a;
            b_out     <= b;
            out_valid <= in_valid;
            val_valid <= 1'b0;
            if (clear) begin
                acc_r     <= {ACC_W{1'b0}};
                cnt_r     <= {CNT_W{1'b0}};
                ovf_acc_r <= 1'b0;
            end else if (in_valid) begin
                if (last_s) begin
                    val       <= res_s;
                    val_valid <= 1'b1;
                    ovf       <= ovf_acc_r | ovf_now_s;
                    acc_r     <= {ACC_W{1'b0}};
                    cnt_r     <= {CNT_W{1'b0}};
                    ovf_acc_r <= 1'b0;
                end else begin
                    acc_r     <= res_s;
                    cnt_r     <= cnt_r + CNT_W'(1);
                    ovf_acc_r <= ovf_acc_r | ovf_now_s;
                end
            end
        end
    end

endmodule
